// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: merges the CPU instruction and data SRAM-like
// ports onto one AXI3 master with read depth and RAW ordering.
module sram_axi_bridge #(
  parameter int RD_DEPTH  = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int CW = $clog2(RD_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RD_DEPTH);

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_AW_W,
    WR_WAIT_B
  } wr_st_e;

  wr_st_e        wr_st_q;
  logic          arvalid_q;
  logic [31:0]   araddr_q;
  logic [2:0]    arsize_q;
  logic [3:0]    arid_q;
  logic          awvalid_q;
  logic          wvalid_q;
  logic [31:0]   awaddr_q;
  logic [2:0]    awsize_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          rr_q;
  logic [CW-1:0] inst_cnt_q;
  logic [CW-1:0] inst_cnt_d;
  logic [CW-1:0] data_cnt_q;
  logic [CW-1:0] data_cnt_d;

  logic ar_free;
  logic wr_busy;
  logic inst_can;
  logic data_rd_can;
  logic data_wr_can;
  logic contest;
  logic inst_gnt;
  logic data_gnt;
  logic inst_ret;
  logic data_ret;
  logic unused_in;

  assign unused_in = ^{inst_sram_wr, inst_sram_wstrb,
                       inst_sram_wdata, rresp, bid, bresp};

  assign ar_free = !arvalid_q || arready;
  assign wr_busy = wr_st_q != WR_IDLE;

  assign inst_can = resetn && inst_sram_req && ar_free &&
                    (inst_cnt_q < DEPTH_C);
  assign data_rd_can = resetn && data_sram_req &&
                       !data_sram_wr && ar_free &&
                       (data_cnt_q < DEPTH_C) && !wr_busy;
  assign data_wr_can = resetn && data_sram_req &&
                       data_sram_wr && !wr_busy &&
                       (data_cnt_q == '0);
  assign contest = inst_can && data_rd_can;

  // One AR grant per cycle; RR favours the port named by rr_q
  always_comb begin
    inst_gnt = inst_can;
    data_gnt = data_rd_can;
    if (contest) begin
      if (PRIO_MODE != 0 && !rr_q) data_gnt = 1'b0;
      else inst_gnt = 1'b0;
    end
  end

  assign inst_ret = rvalid && rlast && (rid == 4'd0);
  assign data_ret = rvalid && rlast && (rid == 4'd1);

  // Outstanding counters: +1 on grant, -1 on last beat
  always_comb begin
    inst_cnt_d = inst_cnt_q + CW'(inst_gnt) - CW'(inst_ret);
    data_cnt_d = data_cnt_q + CW'(data_gnt) - CW'(data_ret);
  end

  // Counter and round-robin pointer state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_cnt_q <= '0;
      data_cnt_q <= '0;
      rr_q       <= 1'b0;
    end else begin
      inst_cnt_q <= inst_cnt_d;
      data_cnt_q <= data_cnt_d;
      if (contest) rr_q <= inst_gnt;
    end
  end

  // AR slot: load on grant, release on handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      arid_q    <= '0;
    end else if (inst_gnt || data_gnt) begin
      arvalid_q <= 1'b1;
      araddr_q  <= data_gnt ? data_sram_addr : inst_sram_addr;
      arsize_q  <= {1'b0, data_gnt ? data_sram_size
                                    : inst_sram_size};
      arid_q    <= data_gnt ? 4'd1 : 4'd0;
    end else if (arready) begin
      arvalid_q <= 1'b0;
    end
  end

  // Single-outstanding write FSM with registered AW/W valids
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_st_q   <= WR_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      unique case (wr_st_q)
        WR_IDLE: begin
          if (data_wr_can) begin
            wr_st_q   <= WR_AW_W;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= data_sram_addr;
            awsize_q  <= {1'b0, data_sram_size};
            wdata_q   <= data_sram_wdata;
            wstrb_q   <= data_sram_wstrb;
          end
        end
        WR_AW_W: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready) wvalid_q <= 1'b0;
          if ((!awvalid_q || awready) &&
              (!wvalid_q || wready)) begin
            wr_st_q <= WR_WAIT_B;
          end
        end
        WR_WAIT_B: begin
          if (bvalid) wr_st_q <= WR_IDLE;
        end
        default: wr_st_q <= WR_IDLE;
      endcase
    end
  end

  assign inst_sram_addr_ok = inst_gnt;
  assign data_sram_addr_ok = data_gnt || data_wr_can;
  assign inst_sram_data_ok = resetn && rvalid && (rid == 4'd0);
  assign data_sram_data_ok = resetn &&
                             ((rvalid && (rid == 4'd1)) || bvalid);
  assign inst_sram_rdata = rdata;
  assign data_sram_rdata = rdata;

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = arvalid_q;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = 1'b1;

  assign awid    = 4'd1;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid    = 4'd1;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign wlast  = 1'b1;
  assign wvalid = wvalid_q;
  assign bready = 1'b1;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: fixed-priority and round-robin bridges
// side by side, checked against a transaction-level model.
module tb_sram_axi_bridge;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        arready, rlast, rvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        awready, wready, bvalid;

  logic [1:0]  i_aok, i_dok, d_aok, d_dok;
  logic [1:0]  arv, awv, wv, rrdy, brdy, wl;
  logic [31:0] i_rd [2];
  logic [31:0] d_rd [2];
  logic [31:0] ara [2];
  logic [31:0] awa [2];
  logic [31:0] wd [2];
  logic [3:0]  ari [2];
  logic [3:0]  awi [2];
  logic [3:0]  wi [2];
  logic [3:0]  ws [2];
  logic [3:0]  arc [2];
  logic [3:0]  awc [2];
  logic [2:0]  ars [2];
  logic [2:0]  aws [2];
  logic [2:0]  arp [2];
  logic [2:0]  awp [2];
  logic [7:0]  arl [2];
  logic [7:0]  awl [2];
  logic [1:0]  arb [2];
  logic [1:0]  awb [2];
  logic [1:0]  ark [2];
  logic [1:0]  awk [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_axi_bridge #(.RD_DEPTH(2), .PRIO_MODE(g)) u_dut (
      .clk(clk), .resetn(resetn),
      .inst_sram_req(inst_req), .inst_sram_wr(inst_wr),
      .inst_sram_size(inst_size), .inst_sram_wstrb(inst_wstrb),
      .inst_sram_addr(inst_addr), .inst_sram_wdata(inst_wdata),
      .inst_sram_addr_ok(i_aok[g]), .inst_sram_data_ok(i_dok[g]),
      .inst_sram_rdata(i_rd[g]),
      .data_sram_req(data_req), .data_sram_wr(data_wr),
      .data_sram_size(data_size), .data_sram_wstrb(data_wstrb),
      .data_sram_addr(data_addr), .data_sram_wdata(data_wdata),
      .data_sram_addr_ok(d_aok[g]), .data_sram_data_ok(d_dok[g]),
      .data_sram_rdata(d_rd[g]),
      .arid(ari[g]), .araddr(ara[g]), .arlen(arl[g]),
      .arsize(ars[g]), .arburst(arb[g]), .arlock(ark[g]),
      .arcache(arc[g]), .arprot(arp[g]), .arvalid(arv[g]),
      .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rrdy[g]),
      .awid(awi[g]), .awaddr(awa[g]), .awlen(awl[g]),
      .awsize(aws[g]), .awburst(awb[g]), .awlock(awk[g]),
      .awcache(awc[g]), .awprot(awp[g]), .awvalid(awv[g]),
      .awready(awready),
      .wid(wi[g]), .wdata(wd[g]), .wstrb(ws[g]), .wlast(wl[g]),
      .wvalid(wv[g]), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(brdy[g])
    );
  end

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // transaction-level model, one per bridge (index = PRIO_MODE)
  int          icnt [2];
  int          dcnt [2];
  bit          ar_p [2];
  bit          aw_p [2];
  bit          w_p [2];
  bit          wr_out [2];
  bit          ptr [2];
  logic [31:0] ar_a [2];
  logic [3:0]  ar_i [2];
  logic [2:0]  ar_s [2];
  logic [31:0] aw_a [2];
  logic [2:0]  aw_s [2];
  logic [31:0] w_d [2];
  logic [3:0]  w_s [2];
  bit af, ic, dc, wc, gi, gd;

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (!resetn) begin
        icnt[m] = 0; dcnt[m] = 0;
        ar_p[m] = 0; aw_p[m] = 0; w_p[m] = 0;
        wr_out[m] = 0; ptr[m] = 0;
        chk($sformatf("rst_arvalid%0d", m), 32'(arv[m]), 0);
        chk($sformatf("rst_awvalid%0d", m), 32'(awv[m]), 0);
        chk($sformatf("rst_wvalid%0d", m), 32'(wv[m]), 0);
        chk($sformatf("rst_iaok%0d", m), 32'(i_aok[m]), 0);
        chk($sformatf("rst_daok%0d", m), 32'(d_aok[m]), 0);
        chk($sformatf("rst_idok%0d", m), 32'(i_dok[m]), 0);
        chk($sformatf("rst_ddok%0d", m), 32'(d_dok[m]), 0);
      end else begin
        af = !ar_p[m] || arready;
        ic = inst_req && af && icnt[m] < 2;
        dc = data_req && !data_wr && af && dcnt[m] < 2 &&
             !wr_out[m];
        wc = data_req && data_wr && !wr_out[m] && dcnt[m] == 0;
        gi = ic;
        gd = dc;
        if (ic && dc) begin
          if (m == 1 && !ptr[m]) gd = 0;
          else gi = 0;
          ptr[m] = gi;
        end
        chk($sformatf("iaok%0d", m), 32'(i_aok[m]), 32'(gi));
        chk($sformatf("daok%0d", m), 32'(d_aok[m]),
            32'(gd || wc));
        chk($sformatf("idok%0d", m), 32'(i_dok[m]),
            32'(rvalid && rid == 0));
        chk($sformatf("ddok%0d", m), 32'(d_dok[m]),
            32'((rvalid && rid == 1) || bvalid));
        chk($sformatf("irdata%0d", m), i_rd[m], rdata);
        chk($sformatf("drdata%0d", m), d_rd[m], rdata);
        chk($sformatf("arvalid%0d", m), 32'(arv[m]), 32'(ar_p[m]));
        if (ar_p[m]) begin
          chk($sformatf("araddr%0d", m), ara[m], ar_a[m]);
          chk($sformatf("arid%0d", m), 32'(ari[m]), 32'(ar_i[m]));
          chk($sformatf("arsize%0d", m), 32'(ars[m]), 32'(ar_s[m]));
        end
        chk($sformatf("awvalid%0d", m), 32'(awv[m]), 32'(aw_p[m]));
        chk($sformatf("wvalid%0d", m), 32'(wv[m]), 32'(w_p[m]));
        if (aw_p[m]) begin
          chk($sformatf("awaddr%0d", m), awa[m], aw_a[m]);
          chk($sformatf("awsize%0d", m), 32'(aws[m]), 32'(aw_s[m]));
        end
        if (w_p[m]) begin
          chk($sformatf("wdata%0d", m), wd[m], w_d[m]);
          chk($sformatf("wstrb%0d", m), 32'(ws[m]), 32'(w_s[m]));
        end
        if (ar_p[m] && arready) ar_p[m] = 0;
        if (gi || gd) begin
          ar_p[m] = 1;
          ar_a[m] = gd ? data_addr : inst_addr;
          ar_i[m] = gd ? 4'd1 : 4'd0;
          ar_s[m] = {1'b0, gd ? data_size : inst_size};
        end
        icnt[m] += int'(gi) - int'(rvalid && rlast && rid == 0);
        dcnt[m] += int'(gd) - int'(rvalid && rlast && rid == 1);
        if (aw_p[m] && awready) aw_p[m] = 0;
        if (w_p[m] && wready) w_p[m] = 0;
        if (bvalid) wr_out[m] = 0;
        if (wc) begin
          wr_out[m] = 1; aw_p[m] = 1; w_p[m] = 1;
          aw_a[m] = data_addr;
          aw_s[m] = {1'b0, data_size};
          w_d[m] = data_wdata;
          w_s[m] = data_wstrb;
        end
      end
    end
  end

  task automatic clr();
    inst_req = 0; inst_wr = 0; inst_size = 2; inst_wstrb = 0;
    inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2; data_wstrb = 0;
    data_addr = 0; data_wdata = 0;
    arready = 1; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    rvalid = 0; awready = 0; wready = 0; bid = 0; bresp = 0;
    bvalid = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input logic [3:0] id, input logic [31:0] d);
    rvalid = 1; rlast = 1; rid = id; rdata = d;
    nxt();
    rvalid = 0; rlast = 0;
  endtask

  string seq [2];
  int ndok;

  initial begin
    clr();
    nxt(); nxt();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("arlen", 32'(arl[m]), 0);
      chk("arburst", 32'(arb[m]), 1);
      chk("awburst", 32'(awb[m]), 1);
      chk("awid", 32'(awi[m]), 1);
      chk("wid", 32'(wi[m]), 1);
      chk("wlast", 32'(wl[m]), 1);
      chk("rready", 32'(rrdy[m]), 1);
      chk("bready", 32'(brdy[m]), 1);
    end
    nxt();
    resetn = 1;
    nxt();

    // single instruction read
    inst_req = 1; inst_addr = 32'h1C00_0000;
    @(negedge clk);
    chk("sr_aok", 32'(i_aok[0]), 1);
    nxt();
    inst_req = 0;
    @(negedge clk);
    chk("sr_arvalid", 32'(arv[0]), 1);
    chk("sr_araddr", ara[0], 32'h1C00_0000);
    chk("sr_arid", 32'(ari[0]), 0);
    chk("sr_arsize", 32'(ars[0]), 2);
    nxt();
    rvalid = 1; rlast = 1; rid = 0; rdata = 32'h0280_0C0C;
    @(negedge clk);
    chk("sr_dok", 32'(i_dok[0]), 1);
    chk("sr_rdata", i_rd[0], 32'h0280_0C0C);
    nxt();
    rvalid = 0; rlast = 0;
    nxt();

    // depth limit
    inst_addr = 32'h1C00_0010;
    for (int k = 0; k < 5; k++) begin
      inst_req = 1;
      if (k == 3) begin
        rvalid = 1; rlast = 1; rid = 0; rdata = 32'h11;
      end
      @(negedge clk);
      chk($sformatf("depth_aok_k%0d", k), 32'(i_aok[0]),
          (k < 2 || k == 4) ? 1 : 0);
      nxt();
      rvalid = 0; rlast = 0;
    end
    inst_req = 0;
    nxt();
    resp(0, 32'h22);
    resp(0, 32'h33);
    nxt();

    // arbitration
    seq[0] = ""; seq[1] = "";
    inst_req = 1; inst_addr = 32'h1C00_0100;
    data_req = 1; data_addr = 32'h0000_0200;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++)
        seq[m] = {seq[m], d_aok[m] ? "D" : (i_aok[m] ? "I" : "-")};
      nxt();
    end
    inst_req = 0; data_req = 0;
    nchk++;
    if (seq[0] != "DDII-") begin
      nfail++;
      $display("FAIL arb_fixed: got %s expected DDII-", seq[0]);
    end
    nchk++;
    if (seq[1] != "IDID-") begin
      nfail++;
      $display("FAIL arb_rr: got %s expected IDID-", seq[1]);
    end
    resp(0, 32'h44); resp(1, 32'h55);
    resp(0, 32'h66); resp(1, 32'h77);
    nxt();

    // write then read same address
    ndok = 0;
    for (int k = 0; k < 9; k++) begin
      data_req = (k <= 6); data_wr = (k == 0);
      data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF;
      data_wstrb = 4'hF;
      wready = (k == 1); awready = (k == 3); bvalid = (k == 5);
      if (k == 8) begin
        rvalid = 1; rlast = 1; rid = 1; rdata = 32'h1234_5678;
      end
      @(negedge clk);
      if (k <= 5 && d_dok[0]) ndok++;
      if (k == 0) chk("raw_wr_aok", 32'(d_aok[0]), 1);
      if (k >= 1 && k <= 5)
        chk($sformatf("raw_hold_k%0d", k), 32'(d_aok[0]), 0);
      if (k == 2) begin
        chk("raw_aw_held", 32'(awv[0]), 1);
        chk("raw_w_done", 32'(wv[0]), 0);
        chk("raw_wdata", wd[0], 32'hDEAD_BEEF);
      end
      if (k == 6) chk("raw_rd_aok", 32'(d_aok[0]), 1);
      if (k == 8) chk("raw_rdata", d_rd[0], 32'h1234_5678);
      nxt();
    end
    clr();
    chk("raw_wr_dok_once", ndok, 1);
    nxt();

    // write waits for pending read
    awready = 1; wready = 1;
    for (int k = 0; k < 10; k++) begin
      data_req = (k <= 5); data_wr = (k >= 1);
      data_addr = (k == 0) ? 32'h200 : 32'h204;
      data_wdata = 32'hA5A5_0001; data_wstrb = 4'h3;
      inst_req = (k == 1 || k == 3);
      inst_addr = 32'h1C00_0200 + 32'(k);
      rvalid = (k == 3 || k == 4 || k == 5); rlast = rvalid;
      rid = (k == 4) ? 4'd1 : 4'd0; rdata = 32'(k);
      bvalid = (k == 8);
      @(negedge clk);
      if (k >= 1 && k <= 4)
        chk($sformatf("wpend_hold_k%0d", k), 32'(d_aok[0]), 0);
      if (k == 5) chk("wpend_go", 32'(d_aok[0]), 1);
      if (k == 1 || k == 3)
        chk($sformatf("wpend_inst_k%0d", k), 32'(i_aok[0]), 1);
      nxt();
    end
    clr();
    nxt();

    // reset mid-transaction
    arready = 0; awready = 1; wready = 1;
    data_req = 1; data_wr = 1; data_addr = 32'h300;
    data_wdata = 32'h0BAD_F00D; data_wstrb = 4'hF;
    inst_req = 1; inst_addr = 32'h1C00_0300;
    @(negedge clk);
    chk("mr_wr_aok", 32'(d_aok[0]), 1);
    chk("mr_rd_aok", 32'(i_aok[0]), 1);
    nxt();
    data_req = 0;
    nxt();
    @(negedge clk);
    chk("mr_arv_pre", 32'(arv[0]), 1);
    @(posedge clk);
    #3;
    resetn = 0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("mr_arv%0d", m), 32'(arv[m]), 0);
      chk($sformatf("mr_awv%0d", m), 32'(awv[m]), 0);
      chk($sformatf("mr_wv%0d", m), 32'(wv[m]), 0);
      chk($sformatf("mr_iaok%0d", m), 32'(i_aok[m]), 0);
    end
    nxt();
    resetn = 1; arready = 1;
    @(negedge clk);
    chk("mr_post_aok", 32'(i_aok[0]), 1);
    nxt();
    inst_req = 0;
    @(negedge clk);
    chk("mr_post_araddr", ara[0], 32'h1C00_0300);
    nxt();
    resp(0, 32'h99);
    nxt(); nxt();

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Parametrised bridge that merges the CPU's two SRAM-like ports (instruction fetch and data access) onto a single AXI3-style master interface. It replaces direct SRAM hookup at the CPU top. It supports a configurable number of outstanding reads per port, a selectable read-arbitration mode, and one outstanding write with read-after-write ordering protection.

## Interface
- RD_DEPTH, 2: maximum outstanding reads per port (1..8).
- PRIO_MODE, 0: read arbitration mode. 0 = fixed, data port wins. 1 = round-robin.
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  reset; one clock, reset is asynchronous and active-low.
- inst_sram_req / wr / size[1:0] / wstrb[3:0] / addr[31:0] / wdata[31:0]  in  instruction port request (wr is always 0).
- inst_sram_addr_ok, inst_sram_data_ok  out  1  instruction port handshakes.
- inst_sram_rdata  out  32  instruction read data.
- data_sram_req / wr / size[1:0] / wstrb[3:0] / addr[31:0] / wdata[31:0]  in  data port request.
- data_sram_addr_ok, data_sram_data_ok  out  1  data port handshakes.
- data_sram_rdata  out  32  data read data.
- arid[3:0], araddr[31:0], arsize[2:0], arvalid  out  read address channel.
- arready  in  1.
- arlen[7:0]=0, arburst[1:0]=01, arlock[1:0]=0, arcache[3:0]=0, arprot[2:0]=0  out  constant AR fields.
- rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid  in  read data channel. rresp is ignored.
- rready  out  1  constant 1.
- awid[3:0]=1, awaddr[31:0], awsize[2:0], awvalid  out  write address channel.
- awlen, awburst, awlock, awcache, awprot  out  constants, same values as the AR constants.
- awready  in  1.
- wid[3:0]=1, wdata[31:0], wstrb[3:0], wlast=1, wvalid  out  write data channel.
- wready  in  1.
- bid[3:0], bresp[1:0], bvalid  in  write response. bresp is ignored.
- bready  out  1  constant 1.

## Operation
- **ID map.** Instruction reads use arid=0. Data reads use arid=1. Writes use id 1.
- **Read acceptance.** A port read request is accepted (addr_ok=1, combinational) when all of the following hold:
  - the AR slot is free, i.e. arvalid=0, or arvalid&&arready in this cycle;
  - the port's outstanding count is below RD_DEPTH;
  - for the data port only: no write is outstanding.
- **Read arbitration.** At most one read is accepted per cycle.
  - PRIO_MODE=0: the data port wins.
  - PRIO_MODE=1: a 1-bit pointer names the favoured port. After each contested grant the pointer moves to the loser. Reset value: instruction port.
- **Read address latch.** On acceptance the bridge latches addr→araddr, {1'b0,size}→arsize and the port id→arid. arvalid rises the next cycle and holds until arready.
- **Read response.** Routing is combinational:
  - inst_sram_data_ok = rvalid&&rid==0;
  - data_sram_data_ok = rvalid&&rid==1 (or a write response, below);
  - both rdata outputs equal rdata.
- **Outstanding counters.** Each per-port counter is $clog2(RD_DEPTH+1) bits wide.
  - +1 on acceptance, −1 on rvalid&&rlast for that id.
  - Simultaneous +1 and −1 leave the counter unchanged.
- **Write acceptance.** A data-port write is accepted (addr_ok=1) when no write is outstanding and the data port read count is 0.
  - Latched: awaddr, awsize, wdata, wstrb.
  - awvalid and wvalid rise the next cycle. Each drops independently on its own handshake.
  - The write stays outstanding until bvalid. data_sram_data_ok = bvalid.
- **Ordering guarantee.** Because of the acceptance rules, data-port read and write responses never coincide, and data-port responses return in request order.
- **Write FSM.**
  - IDLE → AW_W on write accept.
  - AW_W → WAIT_B when both handshakes have completed, same cycle or split across cycles.
  - WAIT_B → IDLE on bvalid.
  - A new write cannot be accepted in the cycle bvalid arrives; the earliest is the next cycle.

## Timing
- **Reset values.** arvalid, awvalid, wvalid, all addr_ok, all data_ok = 0. Counters = 0. Write FSM = IDLE. RR pointer = instruction port. Latched address and data registers = 0.
- **Read latency.** Accept at cycle T. arvalid is high from T+1. The earliest data_ok is one cycle after the AR handshake.
- **Read throughput.** Back-to-back read acceptance, one per cycle, is possible when arready is held high.
- **Reset mid-transaction.** Asynchronous resetn clears all state immediately. In-flight AXI transactions are abandoned; the slave must also be reset.

## Test plan
- **Single instruction read.** inst req addr 0x1C000000, arready=1, rvalid/rid=0/rdata=0x02800C0C one cycle after the AR handshake → addr_ok at T, arvalid at T+1 with arid=0 and arsize=2, inst_sram_data_ok=1 with rdata=0x02800C0C.
- **Depth limit.** RD_DEPTH=2, inst port issues 3 reads, no rvalid → 2 addr_ok, the third stalls. One rlast response → the third is accepted the next cycle.
- **Arbitration.** Both ports request continuously.
  - PRIO_MODE=0: the data port receives every grant while its count < RD_DEPTH.
  - PRIO_MODE=1: grants alternate inst, data, inst, data.
- **Write, then read to the same address.** Data write 0xDEADBEEF to 0x100 with wstrb=0xF, then a data read of 0x100; AW accepted at T+3, W at T+1, B at T+5 → read addr_ok only after the bvalid cycle. Write data_ok=1 exactly once.
- **Write with a read pending.** Data read with its response delayed, then a data write → write addr_ok is held 0 until the read's rlast. Instruction reads proceed meanwhile.
- **Reset mid-transaction.** Drop resetn while arvalid=1 and a write is in WAIT_B → all valids and counters are 0 immediately. The first request after release is accepted normally.
